memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of wait cycles per transaction; 0 disables the timeout.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 FetchRequest  input  1  instruction read request; held until FetchReady.
REQ-005 FetchAddress  input  16  instruction address; stable while FetchRequest is high.
REQ-006 FetchReady  output  1  one-cycle completion pulse for the fetch.
REQ-007 FetchData  output  16  instruction word; valid when FetchReady is high.
REQ-008 DataRead, DataWrite  input  1 each  data requests; held until the matching ready.
REQ-009 DataWidth  input  1  0 = byte, 1 = word; forwarded unchanged.
REQ-010 DataAddress  input  16; DataWriteValue  input  16  data-side address and store value.
REQ-011 DataReadValue  output  16; DataReadReady, DataWriteReady  output  1 each  data-side load value and completion pulses.
REQ-012 MemReadEnable, MemWriteEnable, MemDataWidth  output  1 each  shared memory strobes and width.
REQ-013 MemAddress  output  16; MemWriteData  output  16  shared memory address and store value.
REQ-014 MemReadReady, MemWriteReady  input  1 each; MemReadData  input  16  memory completion signals and load value.
REQ-015 Busy  output  1  high while the FSM is not IDLE.
REQ-016 Timeout  output  1  one-cycle pulse when a transaction is aborted.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DREAD and DWRITE.
REQ-018 In IDLE with a request pending, the FSM SHALL move to the grant state on the next edge, giving one cycle of arbitration latency.
REQ-019 When both DataRead and DataWrite are high, the transaction SHALL be DWRITE; the still-held read is served in a later transaction.
REQ-020 Fetch and data contention SHALL be resolved by the LastGrant register: if LastGrant = data, fetch wins; otherwise data wins.
REQ-021 LastGrant SHALL update to the served side on every completed or aborted transaction.
REQ-022 In FETCH, MemReadEnable SHALL be 1, MemAddress SHALL equal FetchAddress and MemDataWidth SHALL be 1.
REQ-023 In DREAD, MemReadEnable SHALL be 1, and MemAddress/MemDataWidth SHALL equal DataAddress/DataWidth.
REQ-024 In DWRITE, MemWriteEnable SHALL be 1, and MemAddress/MemWriteData/MemDataWidth SHALL equal DataAddress/DataWriteValue/DataWidth.
REQ-025 In IDLE, all Mem strobes SHALL be 0, and MemAddress and MemWriteData SHALL be 0.
REQ-026 The requester's ready SHALL be asserted combinationally in the grant-state cycle where the matching Mem ready is high.
REQ-027 In that completion cycle, FetchData or DataReadValue SHALL equal MemReadData; the FSM SHALL return to IDLE on the next edge.
REQ-028 Ready inputs that do not match the current state SHALL be ignored, including MemWriteReady in FETCH.
REQ-029 FetchData and DataReadValue SHALL be 0 outside their ready cycle.
REQ-030 The 8-bit wait counter SHALL clear on entry to a grant state and increment each grant cycle without the matching ready.
REQ-031 When the count equals TIMEOUT (TIMEOUT ≠ 0), the arbiter SHALL assert the requester's ready with data 0 and pulse Timeout in the same cycle, then go to IDLE.
REQ-032 A requester that drops its request mid-grant is a protocol violation; the arbiter SHALL still wait for memory ready or timeout.
REQ-033 A complete transaction SHALL take at least 2 cycles: grant cycle plus the IDLE cycle.

Reset
REQ-034 While Reset = 0, asynchronously: FSM = IDLE, LastGrant = fetch, counter = 0, and all outputs = 0.
REQ-035 Reset asserted mid-transaction SHALL drop the Mem strobes immediately; no ready pulse is produced for the aborted transaction.
REQ-036 After Reset deasserts, the first arbitration SHALL follow REQ-020 with LastGrant = fetch.

Verification
REQ-037 Fetch with address 0x0010, memory returns 0xA5A5 after 3 cycles -> MemReadEnable high for 3 cycles, then FetchReady = 1 with FetchData = 0xA5A5 for exactly 1 cycle.
REQ-038 Fetch and DataRead asserted together after reset -> DREAD granted first, FETCH next, with IDLE cycles in between.
REQ-039 Both requesters held continuously for 6 transactions -> grants alternate D,F,D,F,D,F.
REQ-040 DataWrite with address 0x0020, value 0x1234, DataWidth = 0 -> MemWriteEnable = 1, MemWriteData = 0x1234, MemDataWidth = 0; DataWriteReady pulses when MemWriteReady = 1.
REQ-041 TIMEOUT = 4 and memory never ready -> ready plus Timeout pulse on the 5th grant cycle (count = 4), with data 0.
REQ-042 Reset low during DREAD wait -> MemReadEnable = 0 the same cycle, Busy = 0, no DataReadReady pulse.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory port between an instruction-fetch requester
// and a data load/store requester.
//   Clock, Reset (async, active-low)
//   Fetch side : FetchRequest, FetchAddress -> FetchReady, FetchData
//   Data side  : DataRead, DataWrite, DataWidth, DataAddress, DataWriteValue
//                -> DataReadValue, DataReadReady, DataWriteReady
//   Memory side: MemReadEnable, MemWriteEnable, MemDataWidth, MemAddress,
//                MemWriteData <- MemReadReady, MemWriteReady, MemReadData
//   Status     : Busy (not idle), Timeout (abort pulse)
// Memory strobes are decoded from the state register. Ready pulses follow the
// memory ready combinationally within the grant cycle.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        FetchRequest,
  input  logic [15:0] FetchAddress,
  output logic        FetchReady,
  output logic [15:0] FetchData,
  input  logic        DataRead,
  input  logic        DataWrite,
  input  logic        DataWidth,
  input  logic [15:0] DataAddress,
  input  logic [15:0] DataWriteValue,
  output logic [15:0] DataReadValue,
  output logic        DataReadReady,
  output logic        DataWriteReady,
  output logic        MemReadEnable,
  output logic        MemWriteEnable,
  output logic        MemDataWidth,
  output logic [15:0] MemAddress,
  output logic [15:0] MemWriteData,
  input  logic        MemReadReady,
  input  logic        MemWriteReady,
  input  logic [15:0] MemReadData,
  output logic        Busy,
  output logic        Timeout
);

  localparam int unsigned CountWidth = 8;
  localparam logic [CountWidth-1:0] TimeoutCount = CountWidth'(TIMEOUT);
  localparam bit TimeoutEnabled = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} state_t;

  state_t                state, nextState;
  logic [CountWidth-1:0] waitCount, nextWaitCount;
  logic                  lastGrantData, nextLastGrantData;
  logic                  memReady;
  logic                  expired;
  logic                  dataRequest;

  assign dataRequest = DataRead | DataWrite;

  // State, wait counter and fairness bit
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      waitCount     <= '0;
      lastGrantData <= 1'b0;
    end else begin
      state         <= nextState;
      waitCount     <= nextWaitCount;
      lastGrantData <= nextLastGrantData;
    end
  end

  // Arbitration, memory strobe decode and completion / timeout handling
  always_comb begin
    nextState         = state;
    nextWaitCount     = waitCount;
    nextLastGrantData = lastGrantData;
    memReady          = 1'b0;
    expired           = 1'b0;
    FetchReady        = 1'b0;
    FetchData         = '0;
    DataReadValue     = '0;
    DataReadReady     = 1'b0;
    DataWriteReady    = 1'b0;
    MemReadEnable     = 1'b0;
    MemWriteEnable    = 1'b0;
    MemDataWidth      = 1'b0;
    MemAddress        = '0;
    MemWriteData      = '0;
    Busy              = (state != IDLE);
    Timeout           = 1'b0;

    case (state)
      IDLE: begin
        nextWaitCount = '0;
        // Fetch wins contention only when data was served last
        if (FetchRequest && (!dataRequest || lastGrantData)) begin
          nextState = FETCH;
        end else if (DataWrite) begin
          nextState = DWRITE;
        end else if (DataRead) begin
          nextState = DREAD;
        end
      end
      FETCH: begin
        MemReadEnable = 1'b1;
        MemAddress    = FetchAddress;
        MemDataWidth  = 1'b1;
        memReady      = MemReadReady;
      end
      DREAD: begin
        MemReadEnable = 1'b1;
        MemAddress    = DataAddress;
        MemDataWidth  = DataWidth;
        memReady      = MemReadReady;
      end
      DWRITE: begin
        MemWriteEnable = 1'b1;
        MemAddress     = DataAddress;
        MemWriteData   = DataWriteValue;
        MemDataWidth   = DataWidth;
        memReady       = MemWriteReady;
      end
      default: nextState = IDLE;
    endcase

    if (state != IDLE) begin
      expired = TimeoutEnabled && !memReady && (waitCount == TimeoutCount);
      if (memReady || expired) begin
        nextState         = IDLE;
        nextWaitCount     = '0;
        nextLastGrantData = (state != FETCH);
        Timeout           = expired;
        // An aborted read returns zero data
        case (state)
          FETCH: begin
            FetchReady = 1'b1;
            FetchData  = memReady ? MemReadData : '0;
          end
          DREAD: begin
            DataReadReady = 1'b1;
            DataReadValue = memReady ? MemReadData : '0;
          end
          default: DataWriteReady = 1'b1;
        endcase
      end else begin
        nextWaitCount = waitCount + CountWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vectors with hand-computed expectations for memory_arbiter.
module tb_memory_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        FetchRequest = 1'b0;
  logic [15:0] FetchAddress = '0;
  logic        FetchReady;
  logic [15:0] FetchData;
  logic        DataRead = 1'b0;
  logic        DataWrite = 1'b0;
  logic        DataWidth = 1'b0;
  logic [15:0] DataAddress = '0;
  logic [15:0] DataWriteValue = '0;
  logic [15:0] DataReadValue;
  logic        DataReadReady;
  logic        DataWriteReady;
  logic        MemReadEnable;
  logic        MemWriteEnable;
  logic        MemDataWidth;
  logic [15:0] MemAddress;
  logic [15:0] MemWriteData;
  logic        MemReadReady = 1'b0;
  logic        MemWriteReady = 1'b0;
  logic [15:0] MemReadData = '0;
  logic        Busy;
  logic        Timeout;

  int checkCount = 0;
  int errorCount = 0;

  memory_arbiter #(.TIMEOUT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .FetchRequest(FetchRequest), .FetchAddress(FetchAddress),
    .FetchReady(FetchReady), .FetchData(FetchData),
    .DataRead(DataRead), .DataWrite(DataWrite), .DataWidth(DataWidth),
    .DataAddress(DataAddress), .DataWriteValue(DataWriteValue),
    .DataReadValue(DataReadValue), .DataReadReady(DataReadReady),
    .DataWriteReady(DataWriteReady),
    .MemReadEnable(MemReadEnable), .MemWriteEnable(MemWriteEnable),
    .MemDataWidth(MemDataWidth), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData),
    .MemReadReady(MemReadReady), .MemWriteReady(MemWriteReady),
    .MemReadData(MemReadData),
    .Busy(Busy), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, " busy"}, 16'(Busy), 16'h0);
    check({tag, " rd en"}, 16'(MemReadEnable), 16'h0);
    check({tag, " wr en"}, 16'(MemWriteEnable), 16'h0);
    check({tag, " addr"}, MemAddress, 16'h0);
    check({tag, " wdata"}, MemWriteData, 16'h0);
    check({tag, " fdata"}, FetchData, 16'h0);
    check({tag, " drdata"}, DataReadValue, 16'h0);
  endtask

  initial begin
    // Reset held with a pending request: nothing may move
    FetchRequest = 1'b1;
    #2;
    checkIdle("reset");
    check("reset fready", 16'(FetchReady), 16'h0);
    check("reset timeout", 16'(Timeout), 16'h0);
    cycle();
    check("reset held busy", 16'(Busy), 16'h0);
    FetchRequest = 1'b0;
    Reset = 1'b1;

    // Fetch 0x0010, memory answers 0xA5A5 on the third grant cycle
    cycle();
    FetchRequest = 1'b1;
    FetchAddress = 16'h0010;
    #1;
    check("arb latency busy", 16'(Busy), 16'h0);
    check("arb latency rd en", 16'(MemReadEnable), 16'h0);
    cycle();
    check("fetch c1 rd en", 16'(MemReadEnable), 16'h1);
    check("fetch c1 addr", MemAddress, 16'h0010);
    check("fetch c1 width", 16'(MemDataWidth), 16'h1);
    check("fetch c1 busy", 16'(Busy), 16'h1);
    check("fetch c1 fready", 16'(FetchReady), 16'h0);
    cycle();
    MemWriteReady = 1'b1;
    #1;
    check("fetch c2 rd en", 16'(MemReadEnable), 16'h1);
    check("fetch ignores wready", 16'(FetchReady), 16'h0);
    cycle();
    MemWriteReady = 1'b0;
    MemReadReady = 1'b1;
    MemReadData = 16'hA5A5;
    #1;
    check("fetch c3 rd en", 16'(MemReadEnable), 16'h1);
    check("fetch c3 fready", 16'(FetchReady), 16'h1);
    check("fetch c3 fdata", FetchData, 16'hA5A5);
    check("fetch c3 timeout", 16'(Timeout), 16'h0);
    cycle();
    FetchRequest = 1'b0;
    MemReadReady = 1'b0;
    #1;
    checkIdle("fetch done");
    check("fetch done fready", 16'(FetchReady), 16'h0);

    // Both requesters held: grants alternate D,F,D,F,D,F
    FetchRequest = 1'b1;
    FetchAddress = 16'h0100;
    DataRead = 1'b1;
    DataAddress = 16'h0200;
    DataWidth = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("alt busy", 16'(Busy), 16'h1);
      check("alt addr", MemAddress, (i % 2 == 0) ? 16'h0200 : 16'h0100);
      MemReadReady = 1'b1;
      MemReadData = 16'(16'h1000 + i);
      #1;
      check("alt dready", 16'(DataReadReady), (i % 2 == 0) ? 16'h1 : 16'h0);
      check("alt fready", 16'(FetchReady), (i % 2 == 0) ? 16'h0 : 16'h1);
      check("alt data", (i % 2 == 0) ? DataReadValue : FetchData, 16'(16'h1000 + i));
      cycle();
      MemReadReady = 1'b0;
      #1;
      check("alt idle gap", 16'(Busy), 16'h0);
    end
    FetchRequest = 1'b0;

    // Read and write together: byte write first, read served afterwards
    DataWrite = 1'b1;
    DataAddress = 16'h0020;
    DataWriteValue = 16'h1234;
    DataWidth = 1'b0;
    cycle();
    MemReadReady = 1'b1;
    #1;
    check("dw wr en", 16'(MemWriteEnable), 16'h1);
    check("dw rd en", 16'(MemReadEnable), 16'h0);
    check("dw wdata", MemWriteData, 16'h1234);
    check("dw width", 16'(MemDataWidth), 16'h0);
    check("dw addr", MemAddress, 16'h0020);
    check("dw ignores rready", 16'(DataWriteReady), 16'h0);
    check("dw no dready", 16'(DataReadReady), 16'h0);
    cycle();
    MemReadReady = 1'b0;
    MemWriteReady = 1'b1;
    #1;
    check("dw wready", 16'(DataWriteReady), 16'h1);
    cycle();
    MemWriteReady = 1'b0;
    DataWrite = 1'b0;
    #1;
    check("dw idle", 16'(Busy), 16'h0);
    check("dw idle wr en", 16'(MemWriteEnable), 16'h0);

    // Held read now granted; memory never answers -> timeout on 5th grant cycle
    MemReadData = 16'hFFFF;
    for (int c = 1; c <= 5; c++) begin
      cycle();
      check("to rd en", 16'(MemReadEnable), 16'h1);
      check("to addr", MemAddress, 16'h0020);
      check("to timeout", 16'(Timeout), (c == 5) ? 16'h1 : 16'h0);
      check("to dready", 16'(DataReadReady), (c == 5) ? 16'h1 : 16'h0);
      check("to data", DataReadValue, 16'h0000);
    end
    cycle();
    DataAddress = 16'h0030;
    #1;
    check("to idle timeout", 16'(Timeout), 16'h0);
    check("to idle busy", 16'(Busy), 16'h0);

    // Reset during a read wait: strobes drop at once, no ready pulse
    cycle();
    check("rst pre rd en", 16'(MemReadEnable), 16'h1);
    Reset = 1'b0;
    MemReadReady = 1'b1;
    #1;
    check("rst rd en", 16'(MemReadEnable), 16'h0);
    check("rst busy", 16'(Busy), 16'h0);
    check("rst dready", 16'(DataReadReady), 16'h0);
    cycle();
    check("rst held dready", 16'(DataReadReady), 16'h0);
    check("rst held busy", 16'(Busy), 16'h0);
    Reset = 1'b1;
    MemReadReady = 1'b0;
    FetchRequest = 1'b1;
    FetchAddress = 16'h0040;

    // After reset LastGrant is fetch, so data wins first
    cycle();
    MemReadReady = 1'b1;
    MemReadData = 16'h5A5A;
    #1;
    check("post rst addr", MemAddress, 16'h0030);
    check("post rst dready", 16'(DataReadReady), 16'h1);
    check("post rst data", DataReadValue, 16'h5A5A);
    cycle();
    MemReadReady = 1'b0;

    // Data served last, so fetch wins the next contention
    cycle();
    MemReadReady = 1'b1;
    MemReadData = 16'h0BEE;
    #1;
    check("fetch win addr", MemAddress, 16'h0040);
    check("fetch win fready", 16'(FetchReady), 16'h1);
    check("fetch win fdata", FetchData, 16'h0BEE);
    check("fetch win no dready", 16'(DataReadReady), 16'h0);
    cycle();
    MemReadReady = 1'b0;
    FetchRequest = 1'b0;
    DataRead = 1'b0;
    #1;
    checkIdle("final");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
